pipe_hazard_ctrl: RTL and testbench

Central hazard and pipeline-control unit that drives the stall, bubble and flush inputs of the IF/ID and ID/EX pipeline registers and the PC. It detects load-use hazards between the instruction in ID and the instruction in EX, and freezes the pipeline while a data-memory access waits for acknowledge. It also squashes wrong-path instructions for a programmable number of cycles after a taken jump, and keeps stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 45 ++++
 rtl/pipe_hazard_ctrl_hazard_cmp.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline definitions for the hazard/control unit.
//   - state_e     : control FSM encoding (RUN / MEM_WAIT / FLUSH)
//   - REG_AW      : register-address width
//   - id_src_t    : source operands of the instruction sitting in ID
//   - ex_dst_t    : destination/load info of the instruction sitting in EX
//   - ex_ctrl_t   : ID/EX control fields; bubble_ctrl() gives the NOP encoding
//                   that id_stall_req selects
`timescale 1ns/1ps
package pipe_hazard_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam int LEFT_W = 4;   // holds FLUSH_CYCLES (1..15)
  localparam int TMO_W  = 8;   // holds MEM_TIMEOUT (2..255)

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } id_src_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              read_mem;
  } ex_dst_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ex_ctrl_t;

  // A bubble is all control fields cleared: no write-back, no memory, no branch.
  function automatic ex_ctrl_t bubble_ctrl(input ex_ctrl_t c, input logic bub);
    return bub ? ex_ctrl_t'('0) : c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// hazard_cmp: pure-combinational load-use detector.
//   i_src       : rs1/rs2 and their use bits for the instruction in ID
//   i_dst       : rd and load flag for the instruction in EX
//   o_load_use  : ID needs a value the EX load has not produced yet
// x0 is hard-wired zero, so a load targeting it never creates a dependency.
`timescale 1ns/1ps
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  id_src_t i_src,
  input  ex_dst_t i_dst,
  output logic    o_load_use
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1  = i_src.use_rs1 && (i_src.rs1 == i_dst.rd);
  assign w_hit_rs2  = i_src.use_rs2 && (i_src.rs2 == i_dst.rd);
  assign o_load_use = i_dst.read_mem && (i_dst.rd != '0) && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall / bubble / flush controller.
//   clk, rst_n          : clock, async active-low reset
//   i_rs1_id..i_use_*   : ID operand info;  i_rd_ex, i_read_mem_ex : EX load info
//   i_jmp_taken_ex      : EX resolved a taken jump
//   i_mem_req/i_mem_ack : data-memory handshake
//   o_pc_stall, o_if_id_stall, o_id_stall_req, o_flush : pipeline controls
//                         (combinational, consumed on the same edge)
//   o_mem_err           : one-cycle pulse when a memory access times out
//   o_stall_cnt/o_flush_cnt : saturating performance counters
`timescale 1ns/1ps
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] i_rs1_id,
  input  logic [REG_AW-1:0] i_rs2_id,
  input  logic              i_use_rs1_id,
  input  logic              i_use_rs2_id,
  input  logic [REG_AW-1:0] i_rd_ex,
  input  logic              i_read_mem_ex,
  input  logic              i_jmp_taken_ex,
  input  logic              i_mem_req,
  input  logic              i_mem_ack,
  output logic              o_pc_stall,
  output logic              o_if_id_stall,
  output logic              o_id_stall_req,
  output logic              o_flush,
  output logic              o_mem_err,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  localparam logic [LEFT_W-1:0] FC_FULL = LEFT_W'(FLUSH_CYCLES);
  localparam logic [LEFT_W-1:0] FC_RELD = LEFT_W'(FLUSH_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(MEM_TIMEOUT);

  state_e            r_state,       w_state_nxt;
  logic [TMO_W-1:0]  r_tmo_cnt,     w_tmo_nxt;
  logic [LEFT_W-1:0] r_flush_left,  w_left_nxt;
  logic [LEFT_W-1:0] r_flush_pend,  w_pend_nxt;
  logic [LEFT_W-1:0] w_left_dec;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_load_use;
  logic w_mem_miss;
  logic w_pc_stall, w_if_id_stall, w_id_stall_req, w_flush, w_mem_err;

  id_src_t w_src;
  ex_dst_t w_dst;

  assign w_src = '{rs1: i_rs1_id, rs2: i_rs2_id, use_rs1: i_use_rs1_id, use_rs2: i_use_rs2_id};
  assign w_dst = '{rd: i_rd_ex, read_mem: i_read_mem_ex};

  hazard_cmp u_cmp (
    .i_src      (w_src),
    .i_dst      (w_dst),
    .o_load_use (w_load_use)
  );

  assign w_mem_miss = i_mem_req && !i_mem_ack;

  always_comb begin
    w_state_nxt    = r_state;
    w_tmo_nxt      = r_tmo_cnt;
    w_left_nxt     = r_flush_left;
    w_pend_nxt     = r_flush_pend;
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_id_stall_req = 1'b0;
    w_flush        = 1'b0;
    w_mem_err      = 1'b0;
    // Flush count owed after this FLUSH cycle; a new jump restarts the window
    // with this cycle as its first flush cycle.
    w_left_dec     = i_jmp_taken_ex ? FC_RELD : (r_flush_left - LEFT_W'(1));

    unique case (r_state)
      ST_RUN: begin
        if (w_mem_miss) begin
          // Freeze first; a jump resolved now is remembered and flushed after
          // the access so stall and flush never overlap.
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_state_nxt   = ST_MEM_WAIT;
          w_tmo_nxt     = TMO_W'(1);
          w_pend_nxt    = i_jmp_taken_ex ? FC_FULL : '0;
        end else if (i_jmp_taken_ex) begin
          w_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = ST_FLUSH;
            w_left_nxt  = FC_RELD;
          end
        end else if (w_load_use) begin
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_stall_req = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        w_pc_stall    = 1'b1;
        w_if_id_stall = 1'b1;
        w_tmo_nxt     = r_tmo_cnt + TMO_W'(1);
        if (i_mem_ack || (r_tmo_cnt == TMO_MAX)) begin
          w_mem_err = !i_mem_ack;
          if (r_flush_pend != '0) begin
            w_state_nxt = ST_FLUSH;
            w_left_nxt  = r_flush_pend;
            w_pend_nxt  = '0;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end

      ST_FLUSH: begin
        w_flush = 1'b1;
        if (w_mem_miss) begin
          // This cycle still flushes and is consumed; the rest resumes after
          // the memory access completes.
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_state_nxt   = ST_MEM_WAIT;
          w_tmo_nxt     = TMO_W'(1);
          w_pend_nxt    = w_left_dec;
          w_left_nxt    = '0;
        end else begin
          w_left_nxt = w_left_dec;
          if (w_left_dec == '0) w_state_nxt = ST_RUN;
        end
      end

      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs forced low during reset even though RUN decodes from live inputs.
  assign o_pc_stall     = rst_n && w_pc_stall;
  assign o_if_id_stall  = rst_n && w_if_id_stall;
  assign o_id_stall_req = rst_n && w_id_stall_req;
  assign o_flush        = rst_n && w_flush;
  assign o_mem_err      = rst_n && w_mem_err;
  assign o_stall_cnt    = r_stall_cnt;
  assign o_flush_cnt    = r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_tmo_cnt    <= '0;
      r_flush_left <= '0;
      r_flush_pend <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_flush_left <= w_left_nxt;
      r_flush_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pc_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush    && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int FC = 2;
  localparam int TO = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1, rs2, rd;
  logic          u1, u2, rmem, jmp, req, ack;
  logic          pcs, ifs, bub, fl, err;
  logic [CW-1:0] scnt, fcnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rs1_id(rs1), .i_rs2_id(rs2), .i_use_rs1_id(u1), .i_use_rs2_id(u2),
    .i_rd_ex(rd), .i_read_mem_ex(rmem), .i_jmp_taken_ex(jmp),
    .i_mem_req(req), .i_mem_ack(ack),
    .o_pc_stall(pcs), .o_if_id_stall(ifs), .o_id_stall_req(bub), .o_flush(fl),
    .o_mem_err(err), .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
  );

  int checks = 0;
  int fails  = 0;
  int errs_seen;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d @%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: "owed" is how many flush cycles remain due starting now,
  // "pend" is flush work deferred behind a memory wait.
  bit      m_wait;
  int      m_waited, m_owed, m_pend;
  longint  m_scnt, m_fcnt;
  bit      e_pcs, e_ifs, e_bub, e_fl, e_err;
  longint  SAT = (longint'(1) << CW) - 1;

  function automatic void model_reset();
    m_wait = 0; m_waited = 0; m_owed = 0; m_pend = 0; m_scnt = 0; m_fcnt = 0;
  endfunction

  function automatic void model_step();
    bit miss, lu;
    miss = req && !ack;
    lu   = rmem && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e_pcs = 0; e_ifs = 0; e_bub = 0; e_fl = 0; e_err = 0;
    if (m_wait) begin
      e_pcs = 1; e_ifs = 1;
      m_waited++;
      if (ack || m_waited == TO) begin
        e_err  = !ack;
        m_wait = 0;
        m_owed = m_pend;
        m_pend = 0;
      end
    end else if (m_owed > 0) begin
      e_fl = 1;
      if (jmp) m_owed = FC;
      m_owed--;
      if (miss) begin
        e_pcs = 1; e_ifs = 1;
        m_wait = 1; m_waited = 0; m_pend = m_owed; m_owed = 0;
      end
    end else if (miss) begin
      e_pcs = 1; e_ifs = 1;
      m_wait = 1; m_waited = 0; m_pend = jmp ? FC : 0;
    end else if (jmp) begin
      e_fl = 1; m_owed = FC - 1;
    end else if (lu) begin
      e_pcs = 1; e_ifs = 1; e_bub = 1;
    end
    if (e_pcs && m_scnt < SAT) m_scnt++;
    if (e_fl  && m_fcnt < SAT) m_fcnt++;
  endfunction

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; rmem = 0; jmp = 0; req = 0; ack = 0;
  endtask

  // Called at posedge+1 with inputs already set; checks mid-cycle, returns at next posedge+1.
  task automatic step();
    longint os, of;
    #3;
    os = m_scnt; of = m_fcnt;
    model_step();
    chk("pc_stall",     pcs,  e_pcs);
    chk("if_id_stall",  ifs,  e_ifs);
    chk("id_stall_req", bub,  e_bub);
    chk("flush",        fl,   e_fl);
    chk("mem_err",      err,  e_err);
    chk("stall_cnt",    scnt, os);
    chk("flush_cnt",    fcnt, of);
    if (err) errs_seen++;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_zero(input string tag);
    chk({tag, "_pcs"},  pcs,  0);
    chk({tag, "_ifs"},  ifs,  0);
    chk({tag, "_bub"},  bub,  0);
    chk({tag, "_fl"},   fl,   0);
    chk({tag, "_err"},  err,  0);
    chk({tag, "_scnt"}, scnt, 0);
    chk({tag, "_fcnt"}, fcnt, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    // Live hazard inputs during reset must not leak to the outputs.
    rs1 = 5; rd = 5; u1 = 1; rmem = 1; jmp = 1; req = 1; ack = 0;
    #2;
    chk_reset_zero("rst");
    @(posedge clk); #1;
    rst_n = 1;
    idle();
    model_reset();
    errs_seen = 0;
  endtask

  initial begin
    idle();
    rst_n = 1;
    #1;
    do_reset();

    // Load-use on rs1: one stall cycle.
    rs1 = 5; u1 = 1; rd = 5; rmem = 1; step();
    idle(); step(); step();
    chk("lu_scnt", scnt, 1);

    // No stall with rd=0, nor with use_rs1 low, nor with a non-load.
    do_reset();
    rs1 = 0; u1 = 1; rd = 0; rmem = 1; step();
    rs1 = 5; u1 = 0; rd = 5; rmem = 1; step();
    rs2 = 7; u2 = 1; rd = 7; rmem = 0; step();
    idle(); step();
    chk("nolu_scnt", scnt, 0);

    // Jump: FC flush cycles; a second jump right after the window adds FC more;
    // a jump in the second flush cycle restarts the window there (1 + FC).
    do_reset();
    jmp = 1; step();
    jmp = 0; step(); step();
    chk("jmp1_fcnt", fcnt, 2);
    jmp = 1; step();
    jmp = 0; step(); step();
    chk("jmp2_fcnt", fcnt, 4);
    jmp = 1; step();
    jmp = 1; step();
    jmp = 0; step(); step();
    chk("jmp3_fcnt", fcnt, 4 + 1 + FC);

    // Memory wait: request then ack three cycles later -> 4 stall cycles.
    do_reset();
    req = 1; step();
    req = 0; step(); step();
    ack = 1; step();
    ack = 0; step();
    chk("mw_pcs_after", pcs, 0);
    chk("mw_scnt", scnt, 4);

    // Memory request with a jump: stall through ack, then FC flush cycles.
    do_reset();
    req = 1; jmp = 1; step();
    idle(); step(); step();
    ack = 1; step();
    idle(); step(); step(); step();
    chk("mj_scnt", scnt, 4);
    chk("mj_fcnt", fcnt, FC);

    // Timeout: no ack ever, exactly one mem_err pulse then back to RUN.
    do_reset();
    req = 1; step();
    idle();
    for (int i = 0; i < TO + 2; i++) step();
    chk("tmo_errs", errs_seen, 1);
    chk("tmo_scnt", scnt, TO + 1);

    // Reset asserted mid-wait clears outputs and counters immediately.
    do_reset();
    req = 1; step();
    req = 0; step();
    #2 rst_n = 0;
    req = 1; jmp = 1; rmem = 1; rd = 3; rs1 = 3; u1 = 1;
    #1;
    chk_reset_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1; idle(); model_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      u1   = 1'($urandom_range(0, 1));
      u2   = 1'($urandom_range(0, 1));
      rmem = 1'($urandom_range(0, 1));
      jmp  = ($urandom_range(0, 99) < 15);
      if (m_wait) begin
        req = 1'($urandom_range(0, 1));
        ack = ($urandom_range(0, 99) < 25);
      end else begin
        req = ($urandom_range(0, 99) < 20);
        ack = req && ($urandom_range(0, 99) < 40);
      end
      step();
    end
    idle(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
